// File: rtl/fpu_ss_wb_arbiter.sv
// Write-back arbiter for the FPU subsystem register file: round-robin between FPU and LSU
// results, single write port, plus a busy scoreboard. Define FPU_SS_WB_REG_EN for a registered write stage.
module fpu_ss_wb_arbiter #(
    parameter int unsigned NumRegs   = 32,
    parameter int unsigned AddrWidth = $clog2(NumRegs)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 issue_valid_i,
    input  logic [AddrWidth-1:0] issue_rd_i,
    output logic                 issue_ready_o,
    output logic [NumRegs-1:0]   busy_o,
    input  logic                 fpu_valid_i,
    output logic                 fpu_ready_o,
    input  logic [AddrWidth-1:0] fpu_rd_i,
    input  logic [31:0]          fpu_data_i,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [AddrWidth-1:0] lsu_rd_i,
    input  logic [31:0]          lsu_data_i,
    output logic                 we_o,
    output logic [AddrWidth-1:0] waddr_o,
    output logic [31:0]          wdata_o
);

    typedef enum logic {
        SRC_FPU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    src_e                 rr_q, rr_d;
    logic [NumRegs-1:0]   busy_q, busy_d;
    logic                 sel_lsu;
    logic                 xfer;
    logic [AddrWidth-1:0] w_rd;
    logic [31:0]          w_data;
    logic                 issue_ok;

    // The grant always resolves to one source, even when idle, so exactly one ready can be high.
    assign sel_lsu     = lsu_valid_i & (~fpu_valid_i | (rr_q == SRC_LSU));
    assign fpu_ready_o = rst_ni & ~sel_lsu;
    assign lsu_ready_o = rst_ni & sel_lsu;

    assign xfer   = sel_lsu ? (lsu_valid_i & lsu_ready_o) : (fpu_valid_i & fpu_ready_o);
    assign w_rd   = sel_lsu ? lsu_rd_i   : fpu_rd_i;
    assign w_data = sel_lsu ? lsu_data_i : fpu_data_i;

    // A result retiring this cycle frees its register in time for a same-cycle reissue.
    assign issue_ready_o = ~busy_q[issue_rd_i] | (xfer & (w_rd == issue_rd_i));
    assign issue_ok      = issue_valid_i & issue_ready_o;
    assign busy_o        = busy_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rr_d   = rr_q;
        busy_d = busy_q;
        if (fpu_valid_i && lsu_valid_i) begin
            rr_d = sel_lsu ? SRC_FPU : SRC_LSU;
        end
        if (xfer) begin
            busy_d[w_rd] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[issue_rd_i] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= SRC_FPU;
            busy_q <= '0;
        end else begin
            rr_q   <= rr_d;
            busy_q <= busy_d;
        end
    end

`ifdef FPU_SS_WB_REG_EN
    logic                 we_q;
    logic [AddrWidth-1:0] waddr_q;
    logic [31:0]          wdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= xfer;
            if (xfer) begin
                waddr_q <= w_rd;
                wdata_q <= w_data;
            end
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
`else
    assign we_o    = xfer;
    assign waddr_o = rst_ni ? w_rd : '0;
    assign wdata_o = rst_ni ? w_data : '0;
`endif

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Directed self-checking bench for fpu_ss_wb_arbiter; expectations follow FPU_SS_WB_REG_EN.
module tb_fpu_ss_wb_arbiter;

`ifdef FPU_SS_WB_REG_EN
    localparam bit Reg = 1'b1;
`else
    localparam bit Reg = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic [4:0]  issue_rd_i = '0;
    logic        issue_ready_o;
    logic [31:0] busy_o;
    logic        fpu_valid_i = 1'b0;
    logic        fpu_ready_o;
    logic [4:0]  fpu_rd_i = '0;
    logic [31:0] fpu_data_i = '0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_i = '0;
    logic [31:0] lsu_data_i = '0;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;

    int tests = 0;
    int fails = 0;

    fpu_ss_wb_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
        .busy_o(busy_o),
        .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o), .fpu_rd_i(fpu_rd_i), .fpu_data_i(fpu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic [4:0] addr, input logic [31:0] data);
        check({tag, "_we"}, {31'd0, we_o}, 32'd1);
        check({tag, "_waddr"}, {27'd0, waddr_o}, {27'd0, addr});
        check({tag, "_wdata"}, wdata_o, data);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_we", {31'd0, we_o}, 32'd0);
        check("rst_waddr", {27'd0, waddr_o}, 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_busy", busy_o, 32'd0);
        check("rst_fpu_ready", {31'd0, fpu_ready_o}, 32'd0);
        check("rst_lsu_ready", {31'd0, lsu_ready_o}, 32'd0);
        #4 rst_ni = 1'b1;
        tick();

        // Single FPU result, one write of one cycle
        fpu_valid_i = 1'b1; fpu_rd_i = 5'd3; fpu_data_i = 32'h3F80_0000;
        #1;
        check("single_fpu_ready", {31'd0, fpu_ready_o}, 32'd1);
        if (!Reg) check_wr("single_comb", 5'd3, 32'h3F80_0000);
        tick();
        fpu_valid_i = 1'b0;
        #1;
        if (Reg) check_wr("single_reg", 5'd3, 32'h3F80_0000);
        else     check("single_comb_done", {31'd0, we_o}, 32'd0);
        tick();
        check("single_one_cycle", {31'd0, we_o}, 32'd0);

        // Contention: both sources valid for four cycles, grants alternate starting at FPU
        fpu_valid_i = 1'b1; fpu_rd_i = 5'd1; fpu_data_i = 32'hA;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd2; lsu_data_i = 32'hB;
        for (int i = 0; i < 4; i++) begin
            logic        exp_lsu;
            logic [4:0]  exp_a;
            logic [31:0] exp_d;
            exp_lsu = i[0];
            exp_a   = exp_lsu ? 5'd2 : 5'd1;
            exp_d   = exp_lsu ? 32'hB : 32'hA;
            #1;
            check($sformatf("rr%0d_fpu_ready", i), {31'd0, fpu_ready_o}, {31'd0, ~exp_lsu});
            check($sformatf("rr%0d_lsu_ready", i), {31'd0, lsu_ready_o}, {31'd0, exp_lsu});
            if (!Reg) check_wr($sformatf("rr%0d_comb", i), exp_a, exp_d);
            tick();
            if (i == 3) begin
                fpu_valid_i = 1'b0;
                lsu_valid_i = 1'b0;
            end
            #1;
            if (Reg) check_wr($sformatf("rr%0d_reg", i), exp_a, exp_d);
        end
        tick();
        check("rr_idle_we", {31'd0, we_o}, 32'd0);
        check("rr_busy_untouched", busy_o, 32'd0);

        // Issue rd=5, WAW stall, then LSU write frees it
        issue_valid_i = 1'b1; issue_rd_i = 5'd5;
        #1;
        check("iss5_ready", {31'd0, issue_ready_o}, 32'd1);
        tick();
        check("iss5_busy", busy_o, 32'h0000_0020);
        check("iss5_waw_stall", {31'd0, issue_ready_o}, 32'd0);
        issue_valid_i = 1'b0;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd5; lsu_data_i = 32'h55AA;
        #1;
        check("iss5_pending_clr", {31'd0, issue_ready_o}, 32'd1);
        tick();
        lsu_valid_i = 1'b0;
        #1;
        check("iss5_cleared", busy_o, 32'd0);
        check("iss5_ready_after", {31'd0, issue_ready_o}, 32'd1);

        // Issue rd=7 while FPU retires rd=7: set wins
        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        fpu_valid_i = 1'b1; fpu_rd_i = 5'd7; fpu_data_i = 32'h7;
        #1;
        check("iss7_ready", {31'd0, issue_ready_o}, 32'd1);
        tick();
        issue_valid_i = 1'b0;
        fpu_valid_i = 1'b0;
        #1;
        check("iss7_set_wins", busy_o, 32'h0000_0080);

        // Build busy = 0x120, then reset right after a transfer
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_data_i = 32'h70;
        issue_valid_i = 1'b1; issue_rd_i = 5'd5;
        tick();
        lsu_valid_i = 1'b0;
        fpu_valid_i = 1'b1; fpu_rd_i = 5'd0; fpu_data_i = 32'h77;
        issue_rd_i = 5'd8;
        tick();
        issue_valid_i = 1'b0;
        #1;
        check("pre_rst_busy", busy_o, 32'h0000_0120);
        check("pre_rst_we", {31'd0, we_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_we", {31'd0, we_o}, 32'd0);
        check("mid_rst_busy", busy_o, 32'd0);
        check("mid_rst_fpu_ready", {31'd0, fpu_ready_o}, 32'd0);
        fpu_valid_i = 1'b0;
        #1 rst_ni = 1'b1;
        tick();

        // Pointer back at FPU after reset
        fpu_valid_i = 1'b1; fpu_rd_i = 5'd10;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd11;
        #1;
        check("post_rst_ptr_fpu", {31'd0, fpu_ready_o}, 32'd1);
        check("post_rst_ptr_lsu", {31'd0, lsu_ready_o}, 32'd0);
        fpu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        tick();

        // LSU-only write, rd=9
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h55;
        #1;
        check("lsu9_ready", {31'd0, lsu_ready_o}, 32'd1);
        if (!Reg) check_wr("lsu9_comb", 5'd9, 32'h55);
        tick();
        lsu_valid_i = 1'b0;
        #1;
        if (Reg) check_wr("lsu9_reg", 5'd9, 32'h55);
        tick();
        check("lsu9_done", {31'd0, we_o}, 32'd0);
        check("final_busy", busy_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
